// File: rtl/lfu_counter_bank_if.sv
// Access / lookup / flush bundle between the LFU victim logic and the
// per-set frequency counter bank.
//   acc_*       : hit-update or refill request (valid/ready handshake)
//   victim_way  : comparator's way select, used as the fill target
//   lookup_set  : set whose four way-counts are presented on count0..3
//   flush_*     : full-bank clear request and its status
// master = initiator side, slave = counter bank.
interface lfu_counter_bank_if #(
  parameter int CNT_W = 4,
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
);
  logic             acc_valid;
  logic             acc_ready;
  logic             acc_fill;
  logic [IDX_W-1:0] acc_set;
  logic [1:0]       acc_way;
  logic [1:0]       victim_way;
  logic [IDX_W-1:0] lookup_set;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;
  logic [CNT_W-1:0] count2;
  logic [CNT_W-1:0] count3;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;

  modport master (
    output acc_valid, acc_fill, acc_set, acc_way, victim_way, lookup_set, flush_req,
    input  acc_ready, count0, count1, count2, count3, flush_busy, flush_done
  );

  modport slave (
    input  acc_valid, acc_fill, acc_set, acc_way, victim_way, lookup_set, flush_req,
    output acc_ready, count0, count1, count2, count3, flush_busy, flush_done
  );
endinterface

// File: rtl/lfu_counter_bank.sv
// Per-set, per-way access-frequency store feeding the LFU victim comparator.
// Hits increment the hit way (aging the whole set by halving when the hit way
// is already saturated), refills set the victim way to 1, and a flush clears
// one set per cycle. count0..3 show the lookup_set counters one cycle later,
// write-first with respect to an update or clear at the same edge.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : lfu_counter_bank_if slave modport
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting accesses (unless flush_req is high this cycle)
// FLUSH | clearing set flush_idx_q this cycle; accesses stalled
module lfu_counter_bank #(
  parameter int CNT_W = 4,
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input logic                  clk,
  input logic                  rst_n,
  lfu_counter_bank_if.slave    bus
);

  localparam int              MAX_I = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(MAX_I);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  // Value given to the hit way after aging: just above every halved count.
  localparam logic [CNT_W-1:0] AGED = CNT_W'((MAX_I >> 1) + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SETS - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   flush_idx_q, flush_idx_d;
  logic [SETS-1:0][3:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0][CNT_W-1:0]              count_q, count_d;
  logic                               acc_ready;
  logic                               flush_done;
  logic                               acc_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      cnt_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    cnt_d       = cnt_q;
    acc_ready   = 1'b0;
    flush_done  = 1'b0;
    acc_take    = 1'b0;

    case (state_q)
      IDLE: begin
        acc_ready = !bus.flush_req;
        acc_take  = bus.acc_valid && acc_ready;
        if (bus.flush_req) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        cnt_d[flush_idx_q] = '0;
        // SETS is a power of 2, so the index wraps back to 0 on its own.
        flush_idx_d = flush_idx_q + IDX_W'(1);
        if (flush_idx_q == LAST) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc_take) begin
      if (bus.acc_fill) begin
        cnt_d[bus.acc_set][bus.victim_way] = ONE;
      end else if (cnt_q[bus.acc_set][bus.acc_way] != MAX) begin
        cnt_d[bus.acc_set][bus.acc_way] = cnt_q[bus.acc_set][bus.acc_way] + ONE;
      end else begin
        for (int i = 0; i < 4; i++) begin
          cnt_d[bus.acc_set][i[1:0]] = cnt_q[bus.acc_set][i[1:0]] >> 1;
        end
        cnt_d[bus.acc_set][bus.acc_way] = AGED;
      end
    end

    // Reading from the next-state array gives write-first behaviour for both
    // updates and flush clears that land on lookup_set at this edge.
    count_d = cnt_d[bus.lookup_set];
  end

  assign bus.acc_ready  = acc_ready;
  assign bus.flush_busy = (state_q == FLUSH);
  assign bus.flush_done = flush_done;
  assign bus.count0     = count_q[0];
  assign bus.count1     = count_q[1];
  assign bus.count2     = count_q[2];
  assign bus.count3     = count_q[3];

endmodule

// File: tb/tb_lfu_counter_bank.sv
module tb_lfu_counter_bank;
  localparam int CNT_W = 4;
  localparam int SETS  = 16;
  localparam int IDX_W = 4;
  localparam int MAXV  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfu_counter_bank_if #(.CNT_W(CNT_W), .SETS(SETS)) bus();
  lfu_counter_bank #(.CNT_W(CNT_W), .SETS(SETS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  // reference model: plain counts per set/way plus flush progress
  int  mcnt [SETS][4];
  bit  mflush;
  int  midx;
  bit  last_busy, last_done;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 4; w++) mcnt[s][w] = 0;
    mflush = 0;
    midx   = 0;
  endtask

  task automatic model_access(input bit fill, input int s, input int w, input int v);
    if (fill) mcnt[s][v] = 1;
    else if (mcnt[s][w] < MAXV) mcnt[s][w] = mcnt[s][w] + 1;
    else begin
      for (int k = 0; k < 4; k++) mcnt[s][k] = mcnt[s][k] / 2;
      mcnt[s][w] = MAXV / 2 + 1;
    end
  endtask

  // Inputs are already driven; checks pre-edge status, clocks, checks counts.
  task automatic step();
    bit exp_ready;
    bit vld, fill, freq;
    int s, w, v, lk;
    #1;
    exp_ready = !mflush && !bus.flush_req;
    last_busy = bus.flush_busy;
    last_done = bus.flush_done;
    chk("acc_ready", int'(bus.acc_ready), int'(exp_ready));
    chk("flush_busy", int'(bus.flush_busy), int'(mflush));
    chk("flush_done", int'(bus.flush_done), int'(mflush && midx == SETS - 1));
    vld = bus.acc_valid; fill = bus.acc_fill; freq = bus.flush_req;
    s = int'(bus.acc_set); w = int'(bus.acc_way); v = int'(bus.victim_way);
    lk = int'(bus.lookup_set);
    @(posedge clk);
    if (mflush) begin
      for (int k = 0; k < 4; k++) mcnt[midx][k] = 0;
      if (midx == SETS - 1) mflush = 0;
      else midx++;
    end else if (freq) begin
      mflush = 1;
      midx   = 0;
    end else if (vld) begin
      model_access(fill, s, w, v);
    end
    #1;
    chk("count0", int'(bus.count0), mcnt[lk][0]);
    chk("count1", int'(bus.count1), mcnt[lk][1]);
    chk("count2", int'(bus.count2), mcnt[lk][2]);
    chk("count3", int'(bus.count3), mcnt[lk][3]);
  endtask

  task automatic acc(input bit fill, input int s, input int w, input int lk);
    bus.acc_valid  = 1'b1;
    bus.acc_fill   = fill;
    bus.acc_set    = IDX_W'(s);
    bus.acc_way    = 2'(w);
    bus.victim_way = 2'(w);
    bus.lookup_set = IDX_W'(lk);
    step();
    bus.acc_valid  = 1'b0;
  endtask

  task automatic idle(input int lk);
    bus.lookup_set = IDX_W'(lk);
    step();
  endtask

  task automatic preload(input int s, input int c0, input int c1, input int c2, input int c3);
    int vals [4];
    vals = '{c0, c1, c2, c3};
    for (int w = 0; w < 4; w++)
      for (int n = 0; n < vals[w]; n++) acc(1'b0, s, w, s);
  endtask

  task automatic expect4(input string tag, input int c0, input int c1, input int c2, input int c3);
    chk({tag, "_c0"}, int'(bus.count0), c0);
    chk({tag, "_c1"}, int'(bus.count1), c1);
    chk({tag, "_c2"}, int'(bus.count2), c2);
    chk({tag, "_c3"}, int'(bus.count3), c3);
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, done_cnt, guard;
    bus.acc_valid = 0; bus.acc_fill = 0; bus.acc_set = '0; bus.acc_way = '0;
    bus.victim_way = '0; bus.lookup_set = '0; bus.flush_req = 0;
    model_reset();
    reset_release();

    // 1: reset state
    idle(3);
    expect4("s1", 0, 0, 0, 0);

    // 2: hits on set 3, last one observed write-first
    acc(0, 3, 1, 3); acc(0, 3, 1, 3); acc(0, 3, 2, 3); acc(0, 3, 1, 3);
    expect4("s2_wf", 0, 3, 1, 0);
    idle(3);
    expect4("s2", 0, 3, 1, 0);

    // 3a: aging on saturated way
    preload(5, 2, 15, 6, 9);
    acc(0, 5, 1, 5);
    expect4("s3a", 1, 8, 3, 4);

    // 4: refill over a saturated victim
    preload(7, 4, 5, 15, 3);
    acc(1, 7, 2, 7);
    expect4("s4", 4, 5, 1, 3);
    idle(3);
    expect4("s4_other", 0, 3, 1, 0);

    // 5: flush with an access held pending throughout
    bus.flush_req = 1'b1;
    bus.acc_valid = 1'b1; bus.acc_fill = 1'b0; bus.acc_set = IDX_W'(2);
    bus.acc_way = 2'd0; bus.lookup_set = IDX_W'(2);
    step();
    bus.flush_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; guard = 0;
    do begin
      step();
      if (last_busy) busy_cnt++;
      if (last_done) done_cnt++;
      guard++;
    end while (last_busy && guard < 40);
    bus.acc_valid = 1'b0;
    chk("s5_busy_cycles", busy_cnt, 16);
    chk("s5_done_pulses", done_cnt, 1);
    chk("s5_late_accept", int'(bus.count0), 1);
    for (int s = 0; s < SETS; s++) idle(s);
    idle(7);
    expect4("s5_set7", 0, 0, 0, 0);

    // 3b: saturated hit way on non-aging path of another way
    preload(5, 4, 15, 7, 2);
    acc(0, 5, 0, 5);
    expect4("s3b", 5, 15, 7, 2);

    // random phase
    for (int n = 0; n < 600; n++) begin
      bus.acc_valid  = ($urandom_range(0, 3) != 0);
      bus.acc_fill   = ($urandom_range(0, 3) == 0);
      bus.acc_set    = IDX_W'($urandom_range(0, 3));
      bus.acc_way    = 2'($urandom_range(0, 3));
      bus.victim_way = 2'($urandom_range(0, 3));
      bus.lookup_set = IDX_W'($urandom_range(0, 3));
      bus.flush_req  = ($urandom_range(0, 99) == 0);
      step();
    end
    bus.acc_valid = 1'b0; bus.flush_req = 1'b0;
    guard = 0;
    while (mflush && guard < 40) begin idle(0); guard++; end

    // 6: reset in the middle of a flush
    preload(10, 3, 0, 2, 0);
    bus.flush_req = 1'b1; bus.lookup_set = IDX_W'(10);
    step();
    bus.flush_req = 1'b0;
    guard = 0;
    while (midx != 6 && guard < 40) begin idle(10); guard++; end
    chk("s6_at_idx6", midx, 6);
    chk("s6_pre_c0", int'(bus.count0), 3);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_busy", int'(bus.flush_busy), 0);
    chk("s6_done", int'(bus.flush_done), 0);
    expect4("s6_rst", 0, 0, 0, 0);
    guard = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.flush_done) guard++;
    end
    chk("s6_no_done", guard, 0);
    reset_release();
    idle(3);
    expect4("s6_s1", 0, 0, 0, 0);
    idle(10);
    expect4("s6_set10", 0, 0, 0, 0);
    acc(0, 10, 1, 10);
    expect4("s6_hit", 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lfu_counter_bank.md
Name: lfu_counter_bank

Overview:
- Per-set, per-way access-frequency store that feeds the LFU victim comparator.
- Counts hits, initialises the filled way on a refill, and ages a set by halving when a counter saturates.
- Presents the four way-counts of a looked-up set to the comparator, and takes the comparator's 2-bit way select back as the fill victim.
- Also provides a sequential flush of all sets.

Parameters:
- CNT_W, 4, width of each frequency counter (MAX = 2^CNT_W-1).
- SETS, 16, number of sets. Must be a power of 2, minimum 2.
- IDX_W, $clog2(SETS), set index width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- acc_valid  input  1  access request valid.
- acc_ready  output  1  bank can accept an access this cycle.
- acc_fill  input  1  0 = hit update, 1 = refill.
- acc_set  input  IDX_W  set of the access.
- acc_way  input  2  hit way. Used only when acc_fill=0.
- victim_way  input  2  way select from the comparator. Used only when acc_fill=1.
- lookup_set  input  IDX_W  set whose counts are presented.
- count0..count3  output  CNT_W each  counters of ways 0..3 of lookup_set, registered.
- flush_req  input  1  start a full clear.
- flush_busy  output  1  high while flushing.
- flush_done  output  1  one-cycle pulse after the last set is cleared.

Behaviour:
- Storage: SETS x 4 counters of CNT_W bits, all cleared by rst_n.
- Reset values: count0..3 = 0, acc_ready = 1, flush_busy = 0, flush_done = 0, FSM = IDLE, flush index = 0.
- FSM states: IDLE and FLUSH.
  - IDLE -> FLUSH when flush_req=1. This takes priority over a simultaneous access; that access is not accepted.
  - In FLUSH, one set (index 0..SETS-1) is cleared to all-zero per cycle.
  - On clearing index SETS-1, flush_done pulses in that same cycle and the FSM returns to IDLE on the next edge.
  - flush_req while in FLUSH is ignored.
- acc_ready = 1 only in IDLE with flush_req=0. An access is accepted when acc_valid & acc_ready. If not accepted, the initiator holds the request; no state changes.
- Hit update (acc_fill=0) on set s, way w:
  - If cnt[s][w] < MAX: cnt[s][w] += 1; other ways unchanged.
  - If cnt[s][w] == MAX (aging): every way of set s is shifted right by 1, then way w gets (MAX>>1)+1. No wrap to 0 ever occurs.
- Refill (acc_fill=1) on set s: cnt[s][victim_way] = 1; other ways of s unchanged. Applies even if the victim count was MAX.
- One update per cycle; the update takes effect at the accepting edge.
- Count outputs:
  - count0..3 are registered, 1-cycle latency from lookup_set.
  - Write-first: if the update at the same edge targets lookup_set, the outputs show the post-update values.
  - During FLUSH, if the set cleared at that edge equals lookup_set, the outputs show 0.
- Width rules: all arithmetic is in CNT_W bits with explicit saturation/aging; no carry out.
- Reset mid-flush: immediately returns to IDLE, all counters 0, no flush_done pulse.
- acc_set and lookup_set never go out of range because SETS is a power of 2.

Test Plan:
1. Reset, then lookup_set=3 → count0..3 = 0,0,0,0 one cycle later; acc_ready=1.
2. Hits on set 3: way 1 three times, way 2 once → lookup 3 gives 0,3,1,0. A same-cycle lookup of set 3 during the last hit already shows 0,3,1,0 (write-first).
3. Set 5 at 2,15,6,9; hit way 1 → set 5 reads 1,8,3,4. Separately, set 5 at 4,15,7,2; hit way 0 → reads 5,15,7,2 (no aging).
4. Refill set 7 with victim_way=2 while set 7 holds 4,5,15,3 → set 7 reads 4,5,1,3. Other sets unchanged.
5. Preload several sets, then flush_req → flush_busy high for exactly 16 cycles, acc_ready low throughout, flush_done pulses once, all sets read 0. Assert acc_valid during the flush → no counter changes, and the access is accepted the cycle after flush_busy falls.
6. Deassert rst_n at flush index 6 → outputs are 0 and flush_busy=0 immediately, no flush_done; after release the bank behaves as in scenario 1.
